rsa_exp_sequencer: RTL and testbench

- Sequences one RSA modular exponentiation (m^e mod n) on the shared Montgomery multiplier, using left-to-right square-and-multiply.
- Issues multiplier operations one at a time with a start/done handshake and tells the operand-register datapath which register to write back.
- Sits between the start/stop enable logic (GPIO/SPI) and the multiplier/register-file datapath.
- Scans every exponent bit, no leading-zero skip, so the operation count depends only on WIDTH and popcount(e).

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/rsa_exp_sequencer.sv | 102 ++++++++++
 tb/tb_rsa_exp_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and op codes for the RSA exponentiation sequencer
package rsa_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam logic [2:0] OP_XBAR  = 3'd0;
  localparam logic [2:0] OP_INIT  = 3'd1;
  localparam logic [2:0] OP_SQR   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_FINAL = 3'd4;

  function automatic int clog2w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/rsa_exp_sequencer.sv
// rtl/rsa_exp_sequencer.sv - left-to-right square-and-multiply sequencer for the Montgomery multiplier
module rsa_exp_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IW = clog2w(WIDTH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] exponent,
  input  logic             mult_done,
  output logic             mult_start,
  output logic [2:0]       mult_op,
  output logic             xbar_we,
  output logic             acc_we,
  output logic             mult_abort,
  output logic [IW-1:0]    bit_idx,
  output logic             busy,
  output logic             eoc
);

  localparam logic [IW-1:0] TOP_BIT = IW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [IW-1:0]    r_bit_idx, w_bit_idx_nxt;
  logic [WIDTH-1:0] r_e, w_e_nxt;
  logic             w_bit_set;

  assign w_bit_set = r_e[r_bit_idx];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_op      <= OP_XBAR;
      r_bit_idx <= TOP_BIT;
      r_e       <= '0;
    end else if (ena) begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_e       <= w_e_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_bit_idx_nxt = r_bit_idx;
    w_e_nxt       = r_e;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_e_nxt       = exponent;
          w_op_nxt      = OP_XBAR;
          w_bit_idx_nxt = TOP_BIT;
          w_state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (mult_done) w_state_nxt = S_WB;
      S_WB: begin
        w_state_nxt = S_ISSUE;
        case (r_op)
          OP_XBAR: w_op_nxt = OP_INIT;
          OP_INIT: w_op_nxt = OP_SQR;
          OP_SQR, OP_MUL: begin
            // a set bit inserts one MUL after its SQR before the counter moves on
            if (r_op == OP_SQR && w_bit_set) begin
              w_op_nxt = OP_MUL;
            end else if (r_bit_idx == '0) begin
              w_op_nxt = OP_FINAL;
            end else begin
              w_op_nxt      = OP_SQR;
              w_bit_idx_nxt = r_bit_idx - 1'b1;
            end
          end
          default: w_state_nxt = S_DONE;
        endcase
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (stop && r_state != S_IDLE && r_state != S_ABORT) begin
      w_state_nxt = S_ABORT;
    end
  end

  assign mult_start = ena && (r_state == S_ISSUE);
  assign xbar_we    = ena && (r_state == S_WB) && (r_op == OP_XBAR);
  assign acc_we     = ena && (r_state == S_WB) && (r_op != OP_XBAR);
  assign eoc        = ena && (r_state == S_DONE);
  assign mult_abort = ena && (r_state == S_ABORT);
  assign busy       = (r_state != S_IDLE);
  assign mult_op    = r_op;
  assign bit_idx    = r_bit_idx;

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// tb/tb_rsa_exp_sequencer.sv - directed bench for rsa_exp_sequencer with a latency-L multiplier stand-in
module tb_rsa_exp_sequencer;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] exponent = 8'h00;
  logic       mult_done;
  logic       mult_start, xbar_we, acc_we, mult_abort, busy, eoc;
  logic [2:0] mult_op;
  logic [2:0] bit_idx;

  rsa_exp_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start), .stop(stop),
    .exponent(exponent), .mult_done(mult_done), .mult_start(mult_start),
    .mult_op(mult_op), .xbar_we(xbar_we), .acc_we(acc_we),
    .mult_abort(mult_abort), .bit_idx(bit_idx), .busy(busy), .eoc(eoc)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: result valid L cycles after mult_start, frozen with ena.
  logic [7:0] sr = 8'h00;
  int         lat = 3;
  logic       spur = 1'b0;
  always @(posedge clk) begin
    if (!rstb || mult_abort) sr <= 8'h00;
    else if (ena) sr <= {sr[6:0], mult_start};
  end
  assign mult_done = sr[lat-1] | spur;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         t0 = 0;
  int         n_ops, n_x, n_a, n_ab, n_eoc, eoc_cyc;
  logic [2:0] op_log [0:31];
  always @(negedge clk) begin
    if (mult_start) begin
      if (n_ops < 32) op_log[n_ops] = mult_op;
      n_ops++;
    end
    if (xbar_we) n_x++;
    if (acc_we) n_a++;
    if (mult_abort) n_ab++;
    if (eoc) begin
      n_eoc++;
      eoc_cyc = cyc - t0 + 1;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    n_ops = 0; n_x = 0; n_a = 0; n_ab = 0; n_eoc = 0; eoc_cyc = -1;
  endtask

  task automatic launch(input logic [7:0] e, input int l);
    exponent = e;
    lat = l;
    clear_log();
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  // Returns the cycle index of the first cycle in which busy is low.
  task automatic wait_idle(output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        idle_cyc = cyc - t0 + 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Expected op order built straight from the square-and-multiply recipe.
  task automatic check_seq(input string tag, input logic [7:0] e);
    logic [2:0] exp_ops [0:31];
    int n = 0;
    int errs = 0;
    exp_ops[n++] = 3'd0;
    exp_ops[n++] = 3'd1;
    for (int i = 7; i >= 0; i--) begin
      exp_ops[n++] = 3'd2;
      if (e[i]) exp_ops[n++] = 3'd3;
    end
    exp_ops[n++] = 3'd4;
    for (int i = 0; i < n && i < n_ops; i++)
      if (op_log[i] !== exp_ops[i]) errs++;
    chk({tag, "_nops"}, n_ops, n);
    chk({tag, "_seq_errs"}, errs, 0);
  endtask

  int idle_c;

  initial begin
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_bit_idx", {29'd0, bit_idx}, 7);
    chk("rst_op", {29'd0, mult_op}, 0);
    chk("rst_strobes", {27'd0, mult_start, xbar_we, acc_we, mult_abort, eoc}, 0);
    rstb = 1'b1;
    @(posedge clk); #1;

    // e=81, L=3: 13 ops, eoc at 66, idle at 67
    launch(8'h81, 3);
    wait_idle(idle_c);
    check_seq("e81", 8'h81);
    chk("e81_xbar_we", n_x, 1);
    chk("e81_acc_we", n_a, 12);
    chk("e81_eoc_cnt", n_eoc, 1);
    chk("e81_eoc_cyc", eoc_cyc, 66);
    chk("e81_idle_cyc", idle_c, 67);

    // e=00, L=1: 11 ops, no MUL, eoc at 34
    launch(8'h00, 1);
    wait_idle(idle_c);
    check_seq("e00", 8'h00);
    chk("e00_eoc_cyc", eoc_cyc, 34);

    // e=FF, L=2: 19 ops alternating SQR/MUL, eoc at 77
    launch(8'hFF, 2);
    wait_idle(idle_c);
    check_seq("eFF", 8'hFF);
    chk("eFF_eoc_cyc", eoc_cyc, 77);

    // stop during WAIT of the 5th op
    launch(8'hFF, 3);
    repeat (21) begin @(posedge clk); #1; end
    chk("stop_ops_before", n_ops, 5);
    chk("stop_busy_wait", {31'd0, busy}, 1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_abort_pulse", {31'd0, mult_abort}, 1);
    @(posedge clk); #1;
    chk("stop_idle", {31'd0, busy}, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("stop_abort_cnt", n_ab, 1);
    chk("stop_no_eoc", n_eoc, 0);
    chk("stop_acc_we", n_a, 3);
    chk("stop_xbar_we", n_x, 1);
    launch(8'h01, 3);
    wait_idle(idle_c);
    check_seq("e01", 8'h01);
    chk("e01_eoc_cyc", eoc_cyc, 61);

    // ena low for 10 cycles in the first WAIT
    launch(8'h81, 3);
    @(posedge clk); #1;
    ena = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ena = 1'b1;
    wait_idle(idle_c);
    check_seq("ena", 8'h81);
    chk("ena_xbar_we", n_x, 1);
    chk("ena_acc_we", n_a, 12);
    chk("ena_eoc_cyc", eoc_cyc, 76);

    // spurious mult_done in IDLE, then in ISSUE, with start held while busy
    clear_log();
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    chk("spur_idle_busy", {31'd0, busy}, 0);
    launch(8'h03, 3);
    spur = 1'b1;
    start = 1'b1;
    exponent = 8'hFF;
    @(posedge clk); #1;
    spur = 1'b0;
    chk("spur_issue_no_wb", {30'd0, xbar_we, acc_we}, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(idle_c);
    check_seq("spur", 8'h03);
    chk("spur_eoc_cyc", eoc_cyc, 66);

    // reset asserted while in the first WB
    launch(8'h81, 3);
    repeat (4) begin @(posedge clk); #1; end
    chk("rstwb_in_wb", {31'd0, xbar_we}, 1);
    rstb = 1'b0;
    @(posedge clk); #1;
    chk("rstwb_busy", {31'd0, busy}, 0);
    chk("rstwb_strobes", {27'd0, mult_start, xbar_we, acc_we, mult_abort, eoc}, 0);
    chk("rstwb_bit_idx", {29'd0, bit_idx}, 7);
    chk("rstwb_op", {29'd0, mult_op}, 0);
    rstb = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstwb_stays_idle", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
